wb_mem_arbiter: RTL and testbench

Two-master, one-slave Wishbone classic arbiter that shares a single memory slave between the instruction-fetch port (read-only) and the data-memory port (read/write) of the pipeline. It sits between the IF/MEM stage memory masters and the unified memory block. The data port has priority, with a starvation guard so fetch always progresses. Slave responses are routed only to the granted master.

---
 rtl/wb_mem_arbiter_if.sv | 60 ++++++
 rtl/wb_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_mem_arbiter_if.sv
// wb_mem_arbiter_if
// Bundles the three Wishbone classic buses around the memory arbiter:
//   iI_* / oI_*  instruction-fetch master (read-only)
//   iD_* / oD_*  data-memory master (read/write)
//   oS_* / iS_*  shared memory slave
//   oGntI/oGntD  registered grant status
// Modports:
//   slave  - the arbiter's view (it terminates both master buses)
//   master - the surrounding environment: both masters plus the memory slave
interface wb_mem_arbiter_if;
  logic        iI_cyc;
  logic        iI_stb;
  logic [31:0] iI_adr;
  logic [31:0] oI_dat;
  logic        oI_ack;
  logic        oI_err;

  logic        iD_cyc;
  logic        iD_stb;
  logic        iD_we;
  logic [3:0]  iD_sel;
  logic [31:0] iD_adr;
  logic [31:0] iD_dat;
  logic [31:0] oD_dat;
  logic        oD_ack;
  logic        oD_err;

  logic        oS_cyc;
  logic        oS_stb;
  logic        oS_we;
  logic [3:0]  oS_sel;
  logic [31:0] oS_adr;
  logic [31:0] oS_dat;
  logic [31:0] iS_dat;
  logic        iS_ack;
  logic        iS_err;

  logic        oGntI;
  logic        oGntD;

  modport slave (
    input  iI_cyc, iI_stb, iI_adr,
    output oI_dat, oI_ack, oI_err,
    input  iD_cyc, iD_stb, iD_we, iD_sel, iD_adr, iD_dat,
    output oD_dat, oD_ack, oD_err,
    output oS_cyc, oS_stb, oS_we, oS_sel, oS_adr, oS_dat,
    input  iS_dat, iS_ack, iS_err,
    output oGntI, oGntD
  );

  modport master (
    output iI_cyc, iI_stb, iI_adr,
    input  oI_dat, oI_ack, oI_err,
    output iD_cyc, iD_stb, iD_we, iD_sel, iD_adr, iD_dat,
    input  oD_dat, oD_ack, oD_err,
    input  oS_cyc, oS_stb, oS_we, oS_sel, oS_adr, oS_dat,
    output iS_dat, iS_ack, iS_err,
    input  oGntI, oGntD
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter
// Two-master / one-slave Wishbone classic arbiter sharing the unified memory
// between the fetch port (read-only) and the data port (read/write). Data has
// priority; after STARVE_LIMIT consecutive data grants taken while fetch was
// waiting, fetch is granted next. Every transfer is followed by one IDLE cycle.
// Ports:
//   iClk  - clock, rising edge
//   nRst  - asynchronous active-low reset
//   bus   - wb_mem_arbiter_if.slave: fetch master, data master, memory slave
//           and the registered grant flags oGntI/oGntD
// Parameters:
//   STARVE_LIMIT - data grants allowed while fetch waits (1..15)
//   TIMEOUT      - watchdog limit in granted cycles (1..65535)
// Optional feature: define WB_ARB_TIMEOUT_EN to add a watchdog that aborts a
// granted cycle with an err pulse after TIMEOUT cycles without ack/err.
module wb_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input logic             iClk,
  input logic             nRst,
  wb_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("wb_mem_arbiter: STARVE_LIMIT or TIMEOUT out of range");
  end

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_nxt;
  logic       req_i;
  logic       req_d;
  logic       term;
  logic       timeout_hit;

  assign req_i = bus.iI_cyc & bus.iI_stb;
  assign req_d = bus.iD_cyc & bus.iD_stb;
  assign term  = bus.iS_ack | bus.iS_err;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wdog;

  // Held at zero while idle so each grant starts counting from zero; the
  // compare against TIMEOUT-1 fires in the TIMEOUT-th silent granted cycle.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      wdog <= '0;
    end else if (state == IDLE) begin
      wdog <= '0;
    end else if (!term) begin
      wdog <= wdog + 16'd1;
    end
  end

  assign timeout_hit = (state != IDLE) && !term && (wdog == WDOG_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_d && !(req_i && (starve_cnt == STARVE_MAX))) begin
          state_nxt = GNT_D;
        end else if (req_i) begin
          state_nxt = GNT_I;
        end
      end
      GNT_I: if (!bus.iI_cyc || term || timeout_hit) state_nxt = IDLE;
      GNT_D: if (!bus.iD_cyc || term || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counts data grants taken over a waiting fetch; any cycle without a fetch
  // request wipes the history, so only an unbroken wait accumulates.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!req_i || (state == IDLE && state_nxt == GNT_I)) begin
      starve_cnt_nxt = '0;
    end else if (state == IDLE && state_nxt == GNT_D && starve_cnt != STARVE_MAX) begin
      starve_cnt_nxt = starve_cnt + 4'd1;
    end
  end

  // Slave side follows the granted master combinationally so a master abort
  // (cyc low) reaches the slave in the same cycle. Responses are qualified by
  // the master's own cyc, which discards acks arriving after an abort; err
  // wins over a simultaneous ack.
  always_comb begin
    bus.oS_cyc = 1'b0;
    bus.oS_stb = 1'b0;
    bus.oS_we  = 1'b0;
    bus.oS_sel = 4'h0;
    bus.oS_adr = '0;
    bus.oS_dat = '0;
    bus.oI_ack = 1'b0;
    bus.oI_err = 1'b0;
    bus.oD_ack = 1'b0;
    bus.oD_err = 1'b0;
    case (state)
      GNT_I: begin
        bus.oS_cyc = bus.iI_cyc & ~timeout_hit;
        bus.oS_stb = bus.iI_stb & ~timeout_hit;
        bus.oS_sel = 4'hF;
        bus.oS_adr = bus.iI_adr;
        bus.oI_ack = bus.iS_ack & ~bus.iS_err & bus.iI_cyc;
        bus.oI_err = (bus.iS_err | timeout_hit) & bus.iI_cyc;
      end
      GNT_D: begin
        bus.oS_cyc = bus.iD_cyc & ~timeout_hit;
        bus.oS_stb = bus.iD_stb & ~timeout_hit;
        bus.oS_we  = bus.iD_we;
        bus.oS_sel = bus.iD_sel;
        bus.oS_adr = bus.iD_adr;
        bus.oS_dat = bus.iD_dat;
        bus.oD_ack = bus.iS_ack & ~bus.iS_err & bus.iD_cyc;
        bus.oD_err = (bus.iS_err | timeout_hit) & bus.iD_cyc;
      end
      default: ;
    endcase
  end

  assign bus.oI_dat = bus.iS_dat;
  assign bus.oD_dat = bus.iS_dat;
  assign bus.oGntI  = (state == GNT_I);
  assign bus.oGntD  = (state == GNT_D);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
module tb_wb_mem_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic iClk;
  logic nRst;
  wb_mem_arbiter_if bus ();

  wb_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(8)) dut (
    .iClk (iClk),
    .nRst (nRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // random-phase state
  logic [31:0] mem [16];
  logic [31:0] i_adr, d_adr, d_dat, e_adr, e_dat;
  logic [3:0]  d_sel, e_sel;
  logic        i_act, d_act, d_we, s_req, s_ack, e_cyc, i_drop;
  int          m_own, m_nxt, own_prev, m_starve, lat_cnt, lat_tgt, ng;
  int          gseq [6];
  int          gexp [6];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic clr_all();
    bus.iI_cyc = 1'b0; bus.iI_stb = 1'b0; bus.iI_adr = '0;
    bus.iD_cyc = 1'b0; bus.iD_stb = 1'b0; bus.iD_we = 1'b0;
    bus.iD_sel = 4'h0; bus.iD_adr = '0;  bus.iD_dat = '0;
    bus.iS_dat = '0;   bus.iS_ack = 1'b0; bus.iS_err = 1'b0;
  endtask

  initial begin
    nRst = 1'b0;
    clr_all();
    // reset: requests and a slave ack present must not leak through
    bus.iD_cyc = 1'b1; bus.iD_stb = 1'b1; bus.iD_we = 1'b1; bus.iD_sel = 4'hF;
    bus.iD_adr = 32'h40; bus.iD_dat = 32'h1234; bus.iS_ack = 1'b1; bus.iS_err = 1'b1;
    repeat (2) tick();
    chk1("rst_gnt_i", bus.oGntI, 1'b0);
    chk1("rst_gnt_d", bus.oGntD, 1'b0);
    chk1("rst_s_cyc", bus.oS_cyc, 1'b0);
    chk1("rst_s_stb", bus.oS_stb, 1'b0);
    chk1("rst_s_we", bus.oS_we, 1'b0);
    chk32("rst_s_sel", {28'd0, bus.oS_sel}, 32'd0);
    chk32("rst_s_adr", bus.oS_adr, 32'd0);
    chk32("rst_s_dat", bus.oS_dat, 32'd0);
    chk32("rst_resp", {28'd0, bus.oI_ack, bus.oI_err, bus.oD_ack, bus.oD_err}, 32'd0);
    clr_all();
    tick();
    nRst = 1'b1;
    tick();

    // fetch only, slave acks two cycles after the grant
    bus.iI_cyc = 1'b1; bus.iI_stb = 1'b1; bus.iI_adr = 32'h0000_0100;
    #1;
    chk1("fetch_req_gnt", bus.oGntI, 1'b0);
    chk1("fetch_req_scyc", bus.oS_cyc, 1'b0);
    tick();
    chk1("fetch_gnt_i", bus.oGntI, 1'b1);
    chk1("fetch_s_cyc", bus.oS_cyc, 1'b1);
    chk1("fetch_s_we", bus.oS_we, 1'b0);
    chk32("fetch_s_sel", {28'd0, bus.oS_sel}, 32'hF);
    chk32("fetch_s_adr", bus.oS_adr, 32'h100);
    chk32("fetch_s_dat", bus.oS_dat, 32'h0);
    tick();
    chk1("fetch_wait_ack", bus.oI_ack, 1'b0);
    tick();
    bus.iS_ack = 1'b1; bus.iS_dat = 32'h0000_0013;
    #1;
    chk1("fetch_ack_i", bus.oI_ack, 1'b1);
    chk32("fetch_dat_i", bus.oI_dat, 32'h13);
    chk1("fetch_ack_d", bus.oD_ack, 1'b0);
    tick();
    clr_all();
    #1;
    chk1("fetch_idle_gnt", bus.oGntI, 1'b0);
    chk1("fetch_idle_ack", bus.oI_ack, 1'b0);

    // contention: data first, one idle cycle, then fetch
    bus.iI_cyc = 1'b1; bus.iI_stb = 1'b1; bus.iI_adr = 32'h100;
    bus.iD_cyc = 1'b1; bus.iD_stb = 1'b1; bus.iD_we = 1'b1;
    bus.iD_adr = 32'h2000; bus.iD_dat = 32'hDEAD_BEEF; bus.iD_sel = 4'hF;
    tick();
    chk1("cont_gnt_d", bus.oGntD, 1'b1);
    chk1("cont_gnt_i", bus.oGntI, 1'b0);
    chk1("cont_s_we", bus.oS_we, 1'b1);
    chk32("cont_s_dat", bus.oS_dat, 32'hDEAD_BEEF);
    chk32("cont_s_adr", bus.oS_adr, 32'h2000);
    bus.iS_ack = 1'b1;
    #1;
    chk1("cont_ack_d", bus.oD_ack, 1'b1);
    chk1("cont_ack_i_masked", bus.oI_ack, 1'b0);
    tick();
    bus.iS_ack = 1'b0; bus.iD_cyc = 1'b0; bus.iD_stb = 1'b0;
    #1;
    chk1("cont_gap_d", bus.oGntD, 1'b0);
    chk1("cont_gap_i", bus.oGntI, 1'b0);
    tick();
    chk1("cont_then_i", bus.oGntI, 1'b1);
    chk32("cont_i_adr", bus.oS_adr, 32'h100);
    bus.iS_ack = 1'b1; bus.iS_dat = 32'hCAFE_0001;
    #1;
    chk1("cont_ack_i", bus.oI_ack, 1'b1);
    tick();
    clr_all();
    tick();

    // starvation: data requests back to back, fetch waits
    gexp = '{2, 2, 2, 2, 1, 2};
    bus.iI_cyc = 1'b1; bus.iI_stb = 1'b1; bus.iI_adr = 32'h300;
    bus.iD_cyc = 1'b1; bus.iD_stb = 1'b1; bus.iD_we = 1'b1;
    bus.iD_adr = 32'h10; bus.iD_dat = 32'h5555_AAAA; bus.iD_sel = 4'h3;
    ng = 0; i_drop = 1'b0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      tick();
      if (i_drop) begin
        bus.iI_cyc = 1'b0; bus.iI_stb = 1'b0; i_drop = 1'b0;
      end
      bus.iS_ack = bus.oGntI | bus.oGntD;
      #1;
      if (bus.oGntD) begin
        gseq[ng] = 2; ng++;
      end else if (bus.oGntI) begin
        gseq[ng] = 1; ng++; i_drop = 1'b1;
      end
    end
    chk32("starve_grant_count", 32'(ng), 32'd6);
    for (int k = 0; k < 6; k++) chk32($sformatf("starve_grant%0d", k), 32'(gseq[k]), 32'(gexp[k]));
    tick();
    clr_all();
    tick();

    // ack and err together: err only
    bus.iD_cyc = 1'b1; bus.iD_stb = 1'b1; bus.iD_we = 1'b0; bus.iD_adr = 32'h44; bus.iD_sel = 4'hF;
    tick();
    bus.iS_ack = 1'b1; bus.iS_err = 1'b1;
    #1;
    chk1("both_err_d", bus.oD_err, 1'b1);
    chk1("both_ack_d", bus.oD_ack, 1'b0);
    chk1("both_err_i", bus.oI_err, 1'b0);
    tick();
    clr_all();
    tick();

    // abort: fetch drops cyc in its third granted cycle
    bus.iI_cyc = 1'b1; bus.iI_stb = 1'b1; bus.iI_adr = 32'h200;
    tick();
    chk1("abort_gnt", bus.oGntI, 1'b1);
    tick();
    tick();
    bus.iI_cyc = 1'b0; bus.iI_stb = 1'b0; bus.iS_ack = 1'b1;
    #1;
    chk1("abort_scyc", bus.oS_cyc, 1'b0);
    chk1("abort_ack_same", bus.oI_ack, 1'b0);
    tick();
    chk1("abort_idle", bus.oGntI, 1'b0);
    chk1("abort_late_ack_i", bus.oI_ack, 1'b0);
    chk1("abort_late_ack_d", bus.oD_ack, 1'b0);
    clr_all();
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog with TIMEOUT=8: silent slave
    bus.iD_cyc = 1'b1; bus.iD_stb = 1'b1; bus.iD_we = 1'b0; bus.iD_adr = 32'h80; bus.iD_sel = 4'hF;
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk1($sformatf("tmo_err_c%0d", k), bus.oD_err, (k == 8));
      chk1($sformatf("tmo_scyc_c%0d", k), bus.oS_cyc, (k != 8));
      tick();
    end
    chk1("tmo_idle", bus.oGntD, 1'b0);
    chk1("tmo_err_done", bus.oD_err, 1'b0);
    clr_all();
    tick();
`endif

    // reset in the middle of a data transfer
    bus.iD_cyc = 1'b1; bus.iD_stb = 1'b1; bus.iD_we = 1'b1;
    bus.iD_adr = 32'h2004; bus.iD_dat = 32'h0BAD_F00D; bus.iD_sel = 4'hF;
    tick();
    #1;
    chk1("mrst_pre_gnt", bus.oGntD, 1'b1);
    bus.iS_ack = 1'b1;
    #1;
    nRst = 1'b0;
    #1;
    chk1("mrst_gnt_d", bus.oGntD, 1'b0);
    chk1("mrst_scyc", bus.oS_cyc, 1'b0);
    chk1("mrst_swe", bus.oS_we, 1'b0);
    chk32("mrst_sadr", bus.oS_adr, 32'h0);
    chk32("mrst_sdat", bus.oS_dat, 32'h0);
    chk1("mrst_ack_d", bus.oD_ack, 1'b0);
    tick();
    clr_all();
    nRst = 1'b1;
    bus.iI_cyc = 1'b1; bus.iI_stb = 1'b1; bus.iI_adr = 32'h400;
    tick();
    chk1("mrst_after_gnt_i", bus.oGntI, 1'b1);
    bus.iS_ack = 1'b1; bus.iS_dat = 32'h7777;
    #1;
    chk1("mrst_after_ack_i", bus.oI_ack, 1'b1);
    tick();
    clr_all();
    tick();

    // randomized traffic against a transfer-level model
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    m_own = 0; m_starve = 0; i_act = 1'b0; d_act = 1'b0;
    i_adr = '0; d_adr = '0; d_dat = '0; d_sel = 4'h0; d_we = 1'b0;
    lat_cnt = 0; lat_tgt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.iI_cyc = i_act; bus.iI_stb = i_act; bus.iI_adr = i_adr;
      bus.iD_cyc = d_act; bus.iD_stb = d_act; bus.iD_we = d_we;
      bus.iD_adr = d_adr; bus.iD_dat = d_dat; bus.iD_sel = d_sel;
      bus.iS_ack = 1'b0; bus.iS_err = 1'b0;
      #1;
      // memory slave with 0..3 cycles of latency
      s_req = bus.oS_cyc & bus.oS_stb;
      s_ack = s_req && (lat_cnt == lat_tgt);
      bus.iS_dat = (s_req && !bus.oS_we) ? mem[bus.oS_adr[5:2]] : $urandom;
      bus.iS_ack = s_ack;
      #1;
      e_cyc = (m_own == 1) ? i_act : (m_own == 2) ? d_act : 1'b0;
      e_adr = (m_own == 1) ? i_adr : (m_own == 2) ? d_adr : 32'h0;
      e_dat = (m_own == 2) ? d_dat : 32'h0;
      e_sel = (m_own == 1) ? 4'hF : (m_own == 2) ? d_sel : 4'h0;
      chk1("rnd_gnt_i", bus.oGntI, (m_own == 1));
      chk1("rnd_gnt_d", bus.oGntD, (m_own == 2));
      chk1("rnd_s_cyc", bus.oS_cyc, e_cyc);
      chk32("rnd_s_adr", bus.oS_adr, e_adr);
      chk1("rnd_s_we", bus.oS_we, (m_own == 2) && d_we);
      chk32("rnd_s_dat", bus.oS_dat, e_dat);
      chk32("rnd_s_sel", {28'd0, bus.oS_sel}, {28'd0, e_sel});
      chk1("rnd_ack_i", bus.oI_ack, (m_own == 1) && s_ack);
      chk1("rnd_ack_d", bus.oD_ack, (m_own == 2) && s_ack);
      chk1("rnd_err", bus.oI_err | bus.oD_err, 1'b0);
      if (m_own == 1 && s_ack) chk32("rnd_dat_i", bus.oI_dat, mem[i_adr[5:2]]);
      if (m_own == 2 && s_ack && !d_we) chk32("rnd_dat_d", bus.oD_dat, mem[d_adr[5:2]]);
      if (m_own == 2 && s_ack && d_we) begin
        for (int b = 0; b < 4; b++) if (d_sel[b]) mem[d_adr[5:2]][8*b +: 8] = d_dat[8*b +: 8];
      end
      // arbitration rules: data first unless fetch has waited STARVE_LIMIT grants
      own_prev = m_own;
      if (m_own == 0) begin
        if (d_act && !(i_act && m_starve == STARVE_LIMIT)) m_nxt = 2;
        else if (i_act) m_nxt = 1;
        else m_nxt = 0;
        if (!i_act || m_nxt == 1) m_starve = 0;
        else if (m_nxt == 2 && m_starve < STARVE_LIMIT) m_starve++;
        m_own = m_nxt;
      end else begin
        if (!i_act) m_starve = 0;
        if (s_ack) m_own = 0;
      end
      // masters: finish, then maybe chain another request
      if (own_prev == 1 && s_ack) begin
        i_act = ($urandom_range(0, 1) == 1);
        i_adr = 32'($urandom_range(0, 15)) << 2;
      end else if (!i_act && $urandom_range(0, 3) == 0) begin
        i_act = 1'b1;
        i_adr = 32'($urandom_range(0, 15)) << 2;
      end
      if ((own_prev == 2 && s_ack) || (!d_act && $urandom_range(0, 1) == 0)) begin
        d_act = (own_prev == 2 && s_ack) ? ($urandom_range(0, 3) != 0) : 1'b1;
        d_we  = ($urandom_range(0, 1) == 1);
        d_adr = 32'($urandom_range(0, 15)) << 2;
        d_dat = $urandom;
        d_sel = 4'($urandom_range(1, 15));
      end
      if (s_req) begin
        if (s_ack) begin
          lat_cnt = 0;
          lat_tgt = $urandom_range(0, 3);
        end else begin
          lat_cnt++;
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
